vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_if.sv | 36 +++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : vga_timing_gen_if
// Purpose   : Raster timing outputs (counts, syncs, visible flag, strobes).
// Revision  : 1.0
// ============================================================================
interface vga_timing_gen_if;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       bright;
    logic       hSync;
    logic       vSync;
    logic       pix_tick;
    logic       frame_tick;

    modport master (
        output hCount,
        output vCount,
        output bright,
        output hSync,
        output vSync,
        output pix_tick,
        output frame_tick
    );

    modport slave (
        input hCount,
        input vCount,
        input bright,
        input hSync,
        input vSync,
        input pix_tick,
        input frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA raster timing: pixel divider, h/v counters, zero-skew syncs.
//            frame_tick is generated only when VGA_FRAME_TICK_EN is defined.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int PIX_DIV   = 4
) (
    input  wire              clk,
    input  wire              reset,
    vga_timing_gen_if.master vga
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(PIX_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic       c_BRIGHT_RST = (H_VISIBLE > 0) && (V_VISIBLE > 0);

    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] w_div_next;
    logic               r_pix_tick;
    logic [9:0]         r_h;
    logic [9:0]         r_v;
    logic [9:0]         w_h_next;
    logic [9:0]         w_v_next;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_bright_next;
    logic               w_hsync_next;
    logic               w_vsync_next;
    logic               r_bright;
    logic               r_hsync;
    logic               r_vsync;

    // Counters advance at the edge that closes the cycle in which pix_tick is high.
    always_comb begin
        w_div_next = (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_ONE;
        w_h_wrap   = (r_h == c_H_LAST);
        w_v_wrap   = (r_v == c_V_LAST);
        w_h_next   = r_h;
        w_v_next   = r_v;
        if (r_pix_tick) begin
            w_h_next = w_h_wrap ? '0 : r_h + 10'd1;
            if (w_h_wrap) begin
                w_v_next = w_v_wrap ? '0 : r_v + 10'd1;
            end
        end
    end

    // Decoding from the next-state counts keeps the registered flags aligned with the counts.
    always_comb begin
        w_bright_next = (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);
        w_hsync_next  = !((w_h_next >= c_HS_START) && (w_h_next < c_HS_END));
        w_vsync_next  = !((w_v_next >= c_VS_START) && (w_v_next < c_VS_END));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div      <= '0;
            r_pix_tick <= 1'b0;
            r_h        <= '0;
            r_v        <= '0;
            r_bright   <= c_BRIGHT_RST;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
        end else begin
            r_div      <= w_div_next;
            r_pix_tick <= (w_div_next == c_DIV_LAST);
            r_h        <= w_h_next;
            r_v        <= w_v_next;
            r_bright   <= w_bright_next;
            r_hsync    <= w_hsync_next;
            r_vsync    <= w_vsync_next;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    logic r_frame_tick;

    // Counts hold at (0, V_VISIBLE) for PIX_DIV clks; only the entering advance strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= r_pix_tick && w_h_wrap && (w_v_next == c_V_VIS);
        end
    end

    assign vga.frame_tick = r_frame_tick;
`else
    assign vga.frame_tick = 1'b0;
`endif

    assign vga.hCount   = r_h;
    assign vga.vCount   = r_v;
    assign vga.bright   = r_bright;
    assign vga.hSync    = r_hsync;
    assign vga.vSync    = r_vsync;
    assign vga.pix_tick = r_pix_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen on a reduced raster.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

    localparam int H_VISIBLE = 16;
    localparam int H_FRONT   = 4;
    localparam int H_SYNC    = 6;
    localparam int H_BACK    = 4;
    localparam int V_VISIBLE = 10;
    localparam int V_FRONT   = 2;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 3;
    localparam int PIX_DIV   = 4;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * PIX_DIV;

`ifdef VGA_FRAME_TICK_EN
    localparam bit FT_EN = 1'b1;
`else
    localparam bit FT_EN = 1'b0;
`endif

    typedef struct {
        int         n;
        logic [9:0] h;
        logic [9:0] v;
        logic       b;
        logic       hs;
        logic       vs;
        logic       pix;
        logic       fr;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   n;
    int   cyc;
    bit   model_on;

    vga_timing_gen_if vif ();

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .PIX_DIV   (PIX_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset_n),
        .vga   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (n=%0d cyc=%0d)", name, act, exp, n, cyc);
        end
    endtask

    // Reference: every output is a function of the clks elapsed since the last reset edge.
    function automatic logic [24:0] model(input int k);
        int p, h, v;
        logic b, hs, vs, pix, fr;
        p   = k / PIX_DIV;
        h   = p % H_TOTAL;
        v   = (p / H_TOTAL) % V_TOTAL;
        b   = (h < H_VISIBLE) && (v < V_VISIBLE);
        hs  = !((h >= H_VISIBLE + H_FRONT) && (h < H_VISIBLE + H_FRONT + H_SYNC));
        vs  = !((v >= V_VISIBLE + V_FRONT) && (v < V_VISIBLE + V_FRONT + V_SYNC));
        pix = (k % PIX_DIV) == PIX_DIV - 1;
        fr  = FT_EN && ((k % PIX_DIV) == 0) && (h == 0) && (v == V_VISIBLE);
        return {10'(h), 10'(v), b, hs, vs, pix, fr};
    endfunction

    function automatic logic [24:0] observed();
        return {vif.hCount, vif.vCount, vif.bright, vif.hSync, vif.vSync,
                vif.pix_tick, vif.frame_tick};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset_n) n = 0;
        else          n++;
        cyc++;
        @(negedge clk);
        if (model_on) check("model", 32'(observed()), 32'(model(n)));
    endtask

    vec_t tbl[$];

    initial begin
        int ticks;
        int last_tick;
        int k;
        bit found;

        checks   = 0;
        errors   = 0;
        n        = 0;
        cyc      = 0;
        model_on = 1'b0;
        reset_n  = 1'b0;

        //         n     h      v      b  hs vs pix fr
        tbl.push_back('{0,    10'd0,  10'd0,  1, 1, 1, 0, 0});
        tbl.push_back('{3,    10'd0,  10'd0,  1, 1, 1, 1, 0});
        tbl.push_back('{4,    10'd1,  10'd0,  1, 1, 1, 0, 0});
        tbl.push_back('{60,   10'd15, 10'd0,  1, 1, 1, 0, 0});
        tbl.push_back('{64,   10'd16, 10'd0,  0, 1, 1, 0, 0});
        tbl.push_back('{79,   10'd19, 10'd0,  0, 1, 1, 1, 0});
        tbl.push_back('{80,   10'd20, 10'd0,  0, 0, 1, 0, 0});
        tbl.push_back('{100,  10'd25, 10'd0,  0, 0, 1, 0, 0});
        tbl.push_back('{104,  10'd26, 10'd0,  0, 1, 1, 0, 0});
        tbl.push_back('{119,  10'd29, 10'd0,  0, 1, 1, 1, 0});
        tbl.push_back('{120,  10'd0,  10'd1,  1, 1, 1, 0, 0});
        tbl.push_back('{1200, 10'd0,  10'd10, 0, 1, 1, 0, 1});
        tbl.push_back('{1201, 10'd0,  10'd10, 0, 1, 1, 0, 0});
        tbl.push_back('{1440, 10'd0,  10'd12, 0, 1, 0, 0, 0});
        tbl.push_back('{1556, 10'd29, 10'd12, 0, 1, 0, 0, 0});
        tbl.push_back('{1680, 10'd0,  10'd14, 0, 1, 1, 0, 0});
        tbl.push_back('{2039, 10'd29, 10'd16, 0, 1, 1, 1, 0});
        tbl.push_back('{2040, 10'd0,  10'd0,  1, 1, 1, 0, 0});
        tbl.push_back('{2044, 10'd1,  10'd0,  1, 1, 1, 0, 0});

        // Reset held for two clks, then released.
        @(negedge clk);
        tick();
        tick();
        check("rst_state", 32'(observed()), {7'd0, 10'd0, 10'd0, 5'b11100});
        reset_n  = 1'b1;
        model_on = 1'b1;

        foreach (tbl[i]) begin
            while (n < tbl[i].n) tick();
            check($sformatf("tbl%0d_h", i),   32'(vif.hCount),   32'(tbl[i].h));
            check($sformatf("tbl%0d_v", i),   32'(vif.vCount),   32'(tbl[i].v));
            check($sformatf("tbl%0d_b", i),   32'(vif.bright),   32'(tbl[i].b));
            check($sformatf("tbl%0d_hs", i),  32'(vif.hSync),    32'(tbl[i].hs));
            check($sformatf("tbl%0d_vs", i),  32'(vif.vSync),    32'(tbl[i].vs));
            check($sformatf("tbl%0d_pix", i), 32'(vif.pix_tick), 32'(tbl[i].pix));
            check($sformatf("tbl%0d_fr", i),  32'(vif.frame_tick), 32'(tbl[i].fr & FT_EN));
        end

        // Two full frames: frame_tick spacing and position.
        ticks     = 0;
        last_tick = 0;
        for (int c = 0; c < 2 * FRAME_CLKS; c++) begin
            tick();
            if (vif.frame_tick === 1'b1) begin
                check("ft_pos", {12'd0, vif.hCount, vif.vCount}, {12'd0, 10'd0, 10'(V_VISIBLE)});
                if (ticks > 0) check("ft_interval", 32'(cyc - last_tick), 32'(FRAME_CLKS));
                last_tick = cyc;
                ticks++;
            end
        end
        check("ft_count", 32'(ticks), FT_EN ? 32'd2 : 32'd0);

        // Mid-frame reset at counts (12,6).
        found = 1'b0;
        k     = 0;
        while (!found && k < 2 * FRAME_CLKS) begin
            tick();
            k++;
            found = (vif.hCount == 10'd12) && (vif.vCount == 10'd6);
        end
        check("reach_12_6", 32'(found), 32'd1);
        reset_n = 1'b0;
        tick();
        check("midrst_counts", {12'd0, vif.hCount, vif.vCount}, 32'd0);
        check("midrst_strobes", {30'd0, vif.pix_tick, vif.frame_tick}, 32'd0);
        reset_n = 1'b1;
        while (n < 1200) tick();
        check("restart_h", 32'(vif.hCount), 32'd0);
        check("restart_v", 32'(vif.vCount), 32'(V_VISIBLE));
        check("restart_fr", 32'(vif.frame_tick), 32'(FT_EN));
        while (n < FRAME_CLKS + 8) tick();

        // Randomized runs with random reset pulses, checked by the model every clk.
        for (int r = 0; r < 15; r++) begin
            int len;
            int rl;
            len = int'($urandom_range(1, 2500));
            rl  = int'($urandom_range(1, 3));
            for (int c = 0; c < len; c++) tick();
            reset_n = 1'b0;
            for (int c = 0; c < rl; c++) tick();
            reset_n = 1'b1;
        end
        for (int c = 0; c < FRAME_CLKS + 4; c++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
